// File: rtl/srff.sv
// Parameterised bank of independent SR flip-flops with synchronous active-low reset.
// Define SRFF_ERR_EN to compile in the registered S=R=1 detector on err.
module srff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               BOTH_MODE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             err
);

  // Out-of-range BOTH_MODE values fall back to clear.
  localparam int MODE = ((BOTH_MODE >= 0) && (BOTH_MODE <= 3)) ? BOTH_MODE : 1;

  logic [WIDTH-1:0] both_val;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    both_val = '0;
    case (MODE)
      0:       both_val = q;
      2:       both_val = '1;
      3:       both_val = ~q;
      default: both_val = '0;
    endcase
  end

  // Each bit picks set, clear, hold or the both-high action independently.
  always_comb begin
    q_next = (S & ~R) | (~S & ~R & q) | (S & R & both_val);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else begin
      q <= q_next;
    end
  end

  assign qn = ~q;

`ifdef SRFF_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= |(S & R);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_srff.sv
// Bench for srff: one WIDTH=1 clear-mode instance and four WIDTH=4 instances (modes 0,2,3,5)
// against a behavioural model, plus directed literal expectations.
module tb_srff;

`ifdef SRFF_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  localparam int          MODES [4] = '{0, 2, 3, 5};
  localparam logic [3:0]  RV4       = 4'b1010;

  // clock/reset block
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       s1, r1;
  logic [3:0] s4, r4;
  logic       q1, qn1, err1;
  logic [3:0] q4  [4];
  logic [3:0] qn4 [4];
  logic       err4[4];

  srff #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .S(s1), .R(r1), .q(q1), .qn(qn1), .err(err1)
  );

  for (genvar k = 0; k < 4; k++) begin : g_w4
    srff #(.WIDTH(4), .RESET_VAL(RV4), .BOTH_MODE(MODES[k])) dut4 (
      .clk(clk), .reset(reset), .S(s4), .R(r4), .q(q4[k]), .qn(qn4[k]), .err(err4[k])
    );
  end

  // scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: rule table applied per bit
  function automatic logic model_bit(input int mode, input logic qb, input logic sb, input logic rb);
    if (sb && !rb) return 1'b1;
    if (!sb && rb) return 1'b0;
    if (!sb && !rb) return qb;
    if (mode == 0) return qb;
    if (mode == 2) return 1'b1;
    if (mode == 3) return !qb;
    return 1'b0;
  endfunction

  logic       known = 1'b0;
  logic       exp_q1, exp_err1;
  logic [3:0] exp_q4 [4];
  logic       exp_err4;

  always @(posedge clk) begin
    if (!reset) begin
      exp_q1   = 1'b0;
      exp_err1 = 1'b0;
      exp_err4 = 1'b0;
      for (int k = 0; k < 4; k++) exp_q4[k] = RV4;
      known = 1'b1;
    end else if (known) begin
      exp_q1   = model_bit(1, exp_q1, s1, r1);
      exp_err1 = ERR_ON && s1 && r1;
      exp_err4 = ERR_ON && ((s4 & r4) != 4'b0);
      for (int k = 0; k < 4; k++)
        for (int b = 0; b < 4; b++)
          exp_q4[k][b] = model_bit(MODES[k], exp_q4[k][b], s4[b], r4[b]);
    end
  end

  // compare process: every negedge once the model is defined
  always @(negedge clk) begin
    if (known) begin
      chk("m_q1",   {3'b0, q1},   {3'b0, exp_q1});
      chk("m_qn1",  {3'b0, qn1},  {3'b0, ~exp_q1});
      chk("m_err1", {3'b0, err1}, {3'b0, exp_err1});
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("m_q4[%0d]", k),   q4[k],            exp_q4[k]);
        chk($sformatf("m_qn4[%0d]", k),  qn4[k],           ~exp_q4[k]);
        chk($sformatf("m_err4[%0d]", k), {3'b0, err4[k]},  {3'b0, exp_err4});
      end
    end
  end

  // driver tasks: wait for negedge, then change inputs 2ns later
  task automatic next_cycle();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input logic rst, input logic a_s, input logic a_r,
                       input logic [3:0] b_s, input logic [3:0] b_r);
    reset = rst; s1 = a_s; r1 = a_r; s4 = b_s; r4 = b_r;
  endtask

  task automatic chk_q4(input string nm, input logic [3:0] e0, input logic [3:0] e2,
                        input logic [3:0] e3, input logic [3:0] e5);
    chk({nm, "_m0"}, q4[0], e0);
    chk({nm, "_m2"}, q4[1], e2);
    chk({nm, "_m3"}, q4[2], e3);
    chk({nm, "_m5"}, q4[3], e5);
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
    repeat (2) @(negedge clk);
    chk("rst_q1",  {3'b0, q1},   4'b0000);
    chk("rst_qn1", {3'b0, qn1},  4'b0001);
    chk("rst_err", {3'b0, err1}, 4'b0000);
    chk_q4("rst_q4", 4'b1010, 4'b1010, 4'b1010, 4'b1010);

    #2 drive(1'b1, 1'b1, 1'b0, 4'b0001, 4'b1000);
    @(negedge clk);
    chk("set_q1", {3'b0, q1}, 4'b0001);
    chk_q4("mix_q4", 4'b0011, 4'b0011, 4'b0011, 4'b0011);

    #2 drive(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    chk("hold_q1", {3'b0, q1}, 4'b0001);

    #2 drive(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    @(negedge clk);
    chk("clr_q1", {3'b0, q1}, 4'b0000);
    #2 drive(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    chk("reset_q1", {3'b0, q1}, 4'b0001);

    #2 drive(1'b1, 1'b1, 1'b1, 4'b0100, 4'b0100);
    @(negedge clk);
    chk("both_q1",   {3'b0, q1},   4'b0000);
    chk("both_err1", {3'b0, err1}, {3'b0, ERR_ON});
    chk_q4("both1_q4", 4'b0011, 4'b0111, 4'b0111, 4'b0011);
    @(negedge clk);
    chk_q4("both2_q4", 4'b0011, 4'b0111, 4'b0011, 4'b0011);
    @(negedge clk);
    chk_q4("both3_q4", 4'b0011, 4'b0111, 4'b0111, 4'b0011);

    #2 drive(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    chk("err_drop", {3'b0, err1}, 4'b0000);
    chk("pre_q1",   {3'b0, q1},   4'b0001);

    // reset asserted between edges: no effect until the next rising edge
    #2 drive(1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
    #1;
    chk("mid_q1", {3'b0, q1}, 4'b0001);
    chk_q4("mid_q4", 4'b0011, 4'b0111, 4'b0111, 4'b0011);
    @(negedge clk);
    chk("mid_rst_q1",  {3'b0, q1},      4'b0000);
    chk("mid_rst_err", {3'b0, err4[0]}, 4'b0000);
    chk_q4("mid_rst_q4", 4'b1010, 4'b1010, 4'b1010, 4'b1010);

    // randomized phase with occasional reset
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      drive(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
